// File: rtl/stream_arb2_rr_pkg.sv
// Shared types for the two-input round-robin stream arbiter.
package stream_arb2_rr_pkg;
    localparam int unsigned N_SRC = 2;
    localparam int unsigned SRC_W = $clog2(N_SRC);
    typedef logic [SRC_W-1:0] src_t;
endpackage

// File: rtl/mux2.sv
// Generic 2:1 data multiplexer; ins packs {in1, in0}.
module mux2 #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] ins,
    input  logic               sel,
    output logic [WIDTH-1:0]   out
);
    assign out = sel ? ins[2*WIDTH-1:WIDTH] : ins[WIDTH-1:0];
endmodule

// File: rtl/stream_arb2_rr_pick2.sv
// Two-input round-robin pick node: prio breaks ties, a lone requester always wins.
// Purely combinational so wider trees can chain these nodes.
module rr_pick2 (
    input  logic v0,
    input  logic v1,
    input  logic prio,
    output logic gnt_valid,
    output logic gnt
);
    always_comb begin
        gnt_valid = v0 | v1;
        gnt       = v1;
        if (v0 && v1) begin
            gnt = prio;
        end
    end
endmodule

// File: rtl/stream_arb2_rr.sv
// Purpose: round-robin merge of two valid/ready streams into one registered output.
// Latency: 1 cycle from acceptance to out_*; full throughput with out_ready held high.
// Backpressure: out_valid && !out_ready (or flush) drops both readys the same cycle; no skid.
module stream_arb2_rr
    import stream_arb2_rr_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_aL,
    input  logic             flush,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready
);
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    src_t             out_src_q, out_src_d;
    src_t             prio_q, prio_d;

    logic             load;
    logic             gnt_valid;
    logic             gnt;
    logic [WIDTH-1:0] mux_dat;

    rr_pick2 u_pick (
        .v0        (in0_valid),
        .v1        (in1_valid),
        .prio      (prio_q),
        .gnt_valid (gnt_valid),
        .gnt       (gnt)
    );

    mux2 #(.WIDTH(WIDTH)) u_mux (
        .ins ({in1_data, in0_data}),
        .sel (gnt),
        .out (mux_dat)
    );

    // The register can take a new entry when empty or draining this cycle.
    assign load      = !flush && (!out_valid_q || out_ready);
    assign in0_ready = load && in0_valid && (gnt == 1'b0);
    assign in1_ready = load && in1_valid && (gnt == 1'b1);

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        prio_d      = prio_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (load) begin
            if (gnt_valid) begin
                out_valid_d = 1'b1;
                out_data_d  = mux_dat;
                out_src_d   = gnt;
                prio_d      = ~gnt;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            prio_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            prio_q      <= prio_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
endmodule

// File: tb/tb_stream_arb2_rr.sv
// Bench for stream_arb2_rr: directed vector table, async-reset sequence, randomised scoreboard run.
module tb_stream_arb2_rr;
    logic        clk = 1'b0;
    logic        rst_aL;
    logic        flush;
    logic        in0_valid, in1_valid;
    logic [31:0] in0_data, in1_data;
    logic        in0_ready, in1_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_src;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    stream_arb2_rr #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_aL    (rst_aL),
        .flush     (flush),
        .in0_valid (in0_valid),
        .in0_data  (in0_data),
        .in0_ready (in0_ready),
        .in1_valid (in1_valid),
        .in1_data  (in1_data),
        .in1_ready (in1_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        fl;
        logic        v0;
        logic [31:0] d0;
        logic        v1;
        logic [31:0] d1;
        logic        ordy;
        logic        r0;
        logic        r1;
        logic        ov;
        logic [31:0] od;
        logic        os;
    } vec_t;

    function automatic vec_t mk(logic fl, logic v0, logic [31:0] d0, logic v1, logic [31:0] d1,
                                logic ordy, logic r0, logic r1, logic ov, logic [31:0] od, logic os);
        vec_t v;
        v.fl = fl; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.ordy = ordy;
        v.r0 = r0; v.r1 = r1; v.ov = ov; v.od = od; v.os = os;
        return v;
    endfunction

    vec_t vecs[$];

    // Reference model state for the random phase
    bit          pv[2];
    int          seq[2];
    int          exp_seq[2];
    int          waitc[2];
    bit          mv;
    logic [31:0] md;
    bit          ms;
    bit          mprio;
    int          acc, emitted, dropped;

    initial begin
        rst_aL = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in0_valid = 1'b0; in1_valid = 1'b0; in0_data = '0; in1_data = '0;
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_src", {31'd0, out_src}, 32'd0);
        @(negedge clk);
        rst_aL = 1'b1;

        //           fl v0 d0     v1 d1     rdy  r0 r1 ov od     os
        vecs.push_back(mk(0, 1, 32'hA5, 0, 32'h00, 1, 1, 0, 1, 32'hA5, 0));
        vecs.push_back(mk(0, 0, 32'h00, 1, 32'h5A, 1, 0, 1, 1, 32'h5A, 1));
        vecs.push_back(mk(0, 1, 32'h10, 1, 32'h20, 1, 1, 0, 1, 32'h10, 0));
        vecs.push_back(mk(0, 1, 32'h11, 1, 32'h20, 1, 0, 1, 1, 32'h20, 1));
        vecs.push_back(mk(0, 1, 32'h11, 1, 32'h21, 1, 1, 0, 1, 32'h11, 0));
        vecs.push_back(mk(0, 1, 32'h12, 1, 32'h21, 1, 0, 1, 1, 32'h21, 1));
        vecs.push_back(mk(0, 1, 32'h33, 0, 32'h00, 1, 1, 0, 1, 32'h33, 0));
        vecs.push_back(mk(0, 1, 32'h12, 1, 32'h44, 0, 0, 0, 1, 32'h33, 0));
        vecs.push_back(mk(0, 1, 32'h12, 1, 32'h44, 0, 0, 0, 1, 32'h33, 0));
        vecs.push_back(mk(0, 1, 32'h12, 1, 32'h44, 0, 0, 0, 1, 32'h33, 0));
        vecs.push_back(mk(0, 1, 32'h12, 1, 32'h44, 1, 0, 1, 1, 32'h44, 1));
        vecs.push_back(mk(0, 1, 32'h12, 1, 32'h45, 0, 0, 0, 1, 32'h44, 1));
        vecs.push_back(mk(1, 1, 32'h12, 1, 32'h45, 0, 0, 0, 0, 32'h44, 1));
        vecs.push_back(mk(0, 1, 32'h55, 1, 32'h66, 1, 1, 0, 1, 32'h55, 0));
        vecs.push_back(mk(0, 0, 32'h00, 0, 32'h00, 1, 0, 0, 0, 32'h55, 0));
        vecs.push_back(mk(0, 1, 32'h77, 1, 32'h88, 1, 0, 1, 1, 32'h88, 1));
        vecs.push_back(mk(1, 1, 32'h77, 1, 32'h89, 1, 0, 0, 0, 32'h88, 1));

        foreach (vecs[i]) begin
            @(negedge clk);
            flush = vecs[i].fl; in0_valid = vecs[i].v0; in0_data = vecs[i].d0;
            in1_valid = vecs[i].v1; in1_data = vecs[i].d1; out_ready = vecs[i].ordy;
            #1;
            chk($sformatf("v%0d_in0_ready", i), {31'd0, in0_ready}, {31'd0, vecs[i].r0});
            chk($sformatf("v%0d_in1_ready", i), {31'd0, in1_ready}, {31'd0, vecs[i].r1});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].ov});
            chk($sformatf("v%0d_out_data", i), out_data, vecs[i].od);
            chk($sformatf("v%0d_out_src", i), {31'd0, out_src}, {31'd0, vecs[i].os});
        end

        // Async reset mid-burst with prio pointing at in1
        @(negedge clk);
        flush = 1'b0; out_ready = 1'b1;
        in0_valid = 1'b1; in0_data = 32'h99; in1_valid = 1'b0;
        @(posedge clk); #1;
        chk("ar_pre_valid", {31'd0, out_valid}, 32'd1);
        chk("ar_pre_data", out_data, 32'h99);
        in1_valid = 1'b1; in1_data = 32'hAA; in0_data = 32'h9A;
        #2;
        rst_aL = 1'b0;
        #1;
        chk("ar_out_valid", {31'd0, out_valid}, 32'd0);
        chk("ar_out_data", out_data, 32'd0);
        chk("ar_out_src", {31'd0, out_src}, 32'd0);
        @(negedge clk);
        rst_aL = 1'b1;
        #1;
        chk("ar_first_conflict_r0", {31'd0, in0_ready}, 32'd1);
        chk("ar_first_conflict_r1", {31'd0, in1_ready}, 32'd0);
        @(posedge clk); #1;
        chk("ar_first_out", out_data, 32'h9A);
        chk("ar_first_src", {31'd0, out_src}, 32'd0);

        // Randomised run against a spec-level model
        @(negedge clk);
        rst_aL = 1'b0; in0_valid = 1'b0; in1_valid = 1'b0; flush = 1'b0;
        #1;
        rst_aL = 1'b1;
        mv = 0; md = '0; ms = 0; mprio = 0;
        acc = 0; emitted = 0; dropped = 0;
        for (int k = 0; k < 2; k++) begin
            pv[k] = 0; seq[k] = 0; exp_seq[k] = 0; waitc[k] = 0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit lm, gv, g, er0, er1;
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (!pv[k] && $urandom_range(0, 9) < 6) begin
                    pv[k] = 1;
                    waitc[k] = 0;
                end
            end
            in0_valid = pv[0]; in0_data = 32'(seq[0] & 32'hFFFF);
            in1_valid = pv[1]; in1_data = 32'h10000 | 32'(seq[1] & 32'hFFFF);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 19) == 0);
            #1;
            lm  = !flush && (!mv || out_ready);
            gv  = pv[0] || pv[1];
            g   = (pv[0] && pv[1]) ? mprio : pv[1];
            er0 = lm && pv[0] && !g;
            er1 = lm && pv[1] && g;
            chk("rnd_in0_ready", {31'd0, in0_ready}, {31'd0, er0});
            chk("rnd_in1_ready", {31'd0, in1_ready}, {31'd0, er1});
            chk("rnd_out_valid", {31'd0, out_valid}, {31'd0, mv});
            if (mv) begin
                chk("rnd_out_data", out_data, md);
                chk("rnd_out_src", {31'd0, out_src}, {31'd0, ms});
            end
            if (out_valid && out_ready && !flush) begin
                chk("rnd_order", {16'd0, out_data[15:0]}, 32'(exp_seq[out_src] & 32'hFFFF));
                chk("rnd_tag", {31'd0, out_data[16]}, {31'd0, out_src});
                exp_seq[out_src]++;
                emitted++;
            end
            if (mv && flush) begin
                exp_seq[ms]++;
                dropped++;
            end
            if (lm && gv) begin
                md = g ? in1_data : in0_data;
                ms = g;
                mv = 1;
                mprio = !g;
                if (pv[!g]) begin
                    waitc[!g]++;
                    chk("rnd_fairness_wait", 32'(waitc[!g]), (waitc[!g] > 1) ? 32'd1 : 32'(waitc[!g]));
                    if (waitc[!g] > 1) begin
                        errors++;
                        $display("FAIL rnd_fairness: src %0d waited %0d transfers, limit 1", !g, waitc[!g]);
                    end
                end
                waitc[g] = 0;
                pv[g] = 0;
                seq[g]++;
                acc++;
            end else if (lm) begin
                mv = 0;
            end
            if (flush) mv = 0;
            @(posedge clk);
        end
        chk("rnd_conservation", 32'(acc), 32'(emitted + dropped + (mv ? 1 : 0)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
